// File: rtl/pes_alu_driver.sv
// pes_alu_driver
// Command-side initiator for the registered pes_alu datapath. Commands arrive
// over a valid/ready interface and are driven into the ALU one per clock. An
// in-flight tracker follows each operation through the ALU latency. The ALU
// result is then captured into a small result FIFO, and results are returned
// in accept order over a valid/ready response interface.
//
// Ports
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_a, cmd_b, cmd_op  : command operands and opcode
//   alu_a, alu_b, alu_op  : registered operands/opcode to the ALU
//   alu_r                 : ALU result, valid ALU_LAT clocks after alu_* change
//   rsp_valid/rsp_ready   : response handshake
//   rsp_r, rsp_op         : result at the FIFO head and its echoed opcode
//   pending               : in-flight operations plus FIFO occupancy
module pes_alu_driver #(
    parameter int WIDTH   = 8,
    parameter int OPW     = 3,
    parameter int ALU_LAT = 1,
    parameter int DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [WIDTH-1:0]       cmd_a,
    input  logic [WIDTH-1:0]       cmd_b,
    input  logic [OPW-1:0]         cmd_op,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [OPW-1:0]         alu_op,
    input  logic [WIDTH-1:0]       alu_r,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_r,
    output logic [OPW-1:0]         rsp_op,
    output logic [$clog2(DEPTH):0] pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] CREDITS = PW'(DEPTH);

    logic                 accept;
    logic                 pop;
    logic                 capture;

    logic [WIDTH-1:0]     alu_a_q, alu_a_d;
    logic [WIDTH-1:0]     alu_b_q, alu_b_d;
    logic [OPW-1:0]       alu_op_q, alu_op_d;

    logic [ALU_LAT:0]     stg_vld_q, stg_vld_d;
    logic [OPW-1:0]       stg_op_q [0:ALU_LAT];
    logic [OPW-1:0]       stg_op_d [0:ALU_LAT];

    logic [OPW+WIDTH-1:0] mem_q [0:DEPTH-1];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        pending_q, pending_d;
    logic [AW-1:0]        wr_idx, rd_idx;

    // Credits count every accepted command until it is popped, so the FIFO
    // always has room for a result by the time it leaves the tracker. Only
    // registered state feeds cmd_ready, so a pop frees a credit a cycle later.
    assign cmd_ready = rst_n && (pending_q < CREDITS);
    assign accept    = cmd_valid && cmd_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign capture   = stg_vld_q[ALU_LAT];

    // Pointers carry one extra wrap bit: equal pointers mean empty, while
    // equal low bits with differing MSBs would mean full.
    assign wr_idx    = wr_ptr_q[AW-1:0];
    assign rd_idx    = rd_ptr_q[AW-1:0];
    assign rsp_valid = (wr_ptr_q != rd_ptr_q);
    assign rsp_r     = mem_q[rd_idx][WIDTH-1:0];
    assign rsp_op    = mem_q[rd_idx][OPW+WIDTH-1:WIDTH];

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign pending   = pending_q;

    always_comb begin
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        stg_vld_d = '0;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pending_d = pending_q;

        if (accept) begin
            alu_a_d  = cmd_a;
            alu_b_d  = cmd_b;
            alu_op_d = cmd_op;
        end

        // Stage 0 marks the command just issued; the last stage lines up with
        // the cycle in which alu_r reflects that command.
        stg_vld_d[0] = accept;
        stg_op_d[0]  = cmd_op;
        for (int i = 1; i <= ALU_LAT; i++) begin
            stg_vld_d[i] = stg_vld_q[i-1];
            stg_op_d[i]  = stg_op_q[i-1];
        end

        if (capture) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;

        case ({accept, pop})
            2'b10:   pending_d = pending_q + 1'b1;
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            stg_vld_q <= '0;
            for (int i = 0; i <= ALU_LAT; i++) stg_op_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pending_q <= '0;
        end else begin
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            stg_vld_q <= stg_vld_d;
            for (int i = 0; i <= ALU_LAT; i++) stg_op_q[i] <= stg_op_d[i];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pending_q <= pending_d;
        end
    end

    // Storage is cleared on reset so the head reads 0 until the first capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (capture) begin
            mem_q[wr_idx] <= {stg_op_q[ALU_LAT], alu_r};
        end
    end

endmodule

// File: tb/tb_pes_alu_driver.sv
module tb_pes_alu_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] r;
    logic [2:0] op;
    int         t;
  } ent_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Three copies of the driver, one per ALU latency; each has its own ALU
  // model, reference model, scoreboard and stimulus.
  for (genvar g = 0; g < 3; g++) begin : h
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

    logic       rst_n;
    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready;
    logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_r, rsp_r, alu_f;
    logic [2:0] cmd_op, alu_op, rsp_op, pending;
    logic       done = 1'b0;
    logic       stream_on = 1'b0;

    ent_t       q[$];
    ent_t       e;
    int         cyc = 0;
    int         acc_n = 0;
    int         pop_n = 0;
    logic [7:0] la, lb;
    logic [2:0] lo;
    logic       wrote = 1'b0;
    logic       ev;

    pes_alu_driver #(.WIDTH(8), .OPW(3), .ALU_LAT(LAT), .DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_r(alu_r),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_r(rsp_r), .rsp_op(rsp_op), .pending(pending)
    );

    // Bench ALU: R = A ^ B ^ op, delayed by LAT registers
    assign alu_f = alu_a ^ alu_b ^ {5'b0, alu_op};
    if (LAT == 0) begin : g_comb
      assign alu_r = alu_f;
    end else begin : g_reg
      logic [7:0] pipe [0:LAT-1];
      always @(posedge clk) begin
        pipe[0] <= alu_f;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
      assign alu_r = pipe[LAT-1];
    end

    task automatic chk(input string n, input int act, input int exp);
      check($sformatf("L%0d %s", LAT, n), act, exp);
    endtask

    task automatic idle(input int n);
      repeat (n) begin
        @(posedge clk);
        #1;
      end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
      int   n = 0;
      logic rdy;
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      forever begin
        @(negedge clk);
        rdy = cmd_ready;
        @(posedge clk);
        #1;
        if (rdy) break;
        n++;
        if (n > 200) begin
          chk("send timeout", 0, 1);
          break;
        end
      end
    endtask

    // Accept side: every accepted command pushes its expected result and the
    // cycle from which it must be visible at the response port.
    always @(posedge clk) begin
      cyc++;
      if (!rst_n) begin
        q.delete();
        acc_n = 0;
        la = 8'h00;
        lb = 8'h00;
        lo = 3'h0;
      end else if (cmd_valid && cmd_ready) begin
        q.push_back('{r: cmd_a ^ cmd_b ^ {5'b0, cmd_op}, op: cmd_op, t: cyc + LAT + 1});
        acc_n++;
        la = cmd_a;
        lb = cmd_b;
        lo = cmd_op;
      end
    end

    // Response monitor: every pop is compared against the queue head
    always @(posedge clk) begin
      if (!rst_n) begin
        pop_n = 0;
      end else if (rsp_valid && rsp_ready) begin
        pop_n++;
        if (q.size() == 0) begin
          chk("unexpected rsp", 1, 0);
        end else begin
          e = q.pop_front();
          chk("rsp_r", int'(rsp_r), int'(e.r));
          chk("rsp_op", int'(rsp_op), int'(e.op));
        end
      end
    end

    // Cycle-level state checks away from the active edge
    always @(negedge clk) begin
      if (!rst_n) begin
        wrote = 1'b0;
        chk("rst cmd_ready", int'(cmd_ready), 0);
        chk("rst rsp_valid", int'(rsp_valid), 0);
        chk("rst rsp_r", int'(rsp_r), 0);
        chk("rst rsp_op", int'(rsp_op), 0);
        chk("rst pending", int'(pending), 0);
        chk("rst alu_a", int'(alu_a), 0);
        chk("rst alu_b", int'(alu_b), 0);
        chk("rst alu_op", int'(alu_op), 0);
      end else begin
        ev = (q.size() != 0) && (q[0].t <= cyc);
        if (ev) wrote = 1'b1;
        chk("rsp_valid", int'(rsp_valid), int'(ev));
        chk("pending", int'(pending), acc_n - pop_n);
        chk("cmd_ready", int'(cmd_ready), int'((acc_n - pop_n) < 4));
        chk("alu_a", int'(alu_a), int'(la));
        chk("alu_b", int'(alu_b), int'(lb));
        chk("alu_op", int'(alu_op), int'(lo));
        if (!wrote) begin
          chk("idle rsp_r", int'(rsp_r), 0);
          chk("idle rsp_op", int'(rsp_op), 0);
        end
      end
    end

    initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_a     = 8'h00;
      cmd_b     = 8'h00;
      cmd_op    = 3'h0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(1);

      // Single operation
      rsp_ready = 1'b1;
      send(8'h6A, 8'h3B, 3'd0);
      cmd_valid = 1'b0;
      idle(6);

      // Back-to-back opcode sweep
      for (int op = 0; op < 8; op++) send(8'h6A, 8'h3B, 3'(op));
      cmd_valid = 1'b0;
      idle(8);

      // Backpressure: only four credits, then a single pop frees one
      rsp_ready = 1'b0;
      for (int op = 0; op < 4; op++) send(8'h6A, 8'h3B, 3'(op));
      cmd_valid = 1'b1;
      cmd_op    = 3'd4;
      idle(4);
      chk("bp pending", int'(pending), 4);
      chk("bp cmd_ready", int'(cmd_ready), 0);
      rsp_ready = 1'b1;
      idle(1);
      rsp_ready = 1'b0;
      send(8'h6A, 8'h3B, 3'd4);
      rsp_ready = 1'b1;
      for (int op = 5; op < 8; op++) send(8'h6A, 8'h3B, 3'(op));
      cmd_valid = 1'b0;
      idle(10);

      // Random stream with rsp_ready toggling every cycle
      stream_on = 1'b1;
      fork
        begin
          for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              cmd_valid = 1'b0;
              idle(1);
            end else begin
              send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
            end
          end
          cmd_valid = 1'b0;
          stream_on = 1'b0;
        end
        begin
          while (stream_on) begin
            @(posedge clk);
            #1;
            rsp_ready = ~rsp_ready;
          end
        end
      join
      rsp_ready = 1'b1;
      idle(10);

      // Reset while op 5 is still in flight
      send(8'h6A, 8'h3B, 3'd5);
      cmd_valid = 1'b0;
      idle(1);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(3);
      send(8'h6A, 8'h3B, 3'd2);
      cmd_valid = 1'b0;
      idle(8);
      chk("drained", q.size(), 0);
      done = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(h[0].done && h[1].done && h[2].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 20000) begin
      total++;
      bad++;
      $display("FAIL timeout: stimulus not finished after %0d cycles, required completion", n);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pes_alu_driver.md
# pes_alu_driver

Command-side initiator for the 8-bit `pes_alu` datapath. It accepts operand/opcode commands over a valid/ready interface and drives them into the registered ALU one per cycle. It tracks each in-flight operation through the ALU's fixed latency, captures `R` into a small result FIFO, and returns results in order over a valid/ready response interface. It replaces the free-running stimulus previously applied by hand, so the ALU can be driven from a sequencer or host.

## Interface
- `WIDTH`, 8: operand and result width.
- `OPW`, 3: opcode width; covers 8 ALU operations.
- `ALU_LAT`, 1: ALU latency in clocks, from an `alu_*` change to `alu_r` reflecting it. Legal range 0..4; 0 means a combinational ALU.
- `DEPTH`, 4: result FIFO depth. Must be a power of two, at least 2.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: driver can accept a command this cycle.
- `cmd_a`, `cmd_b`, input, WIDTH: operands.
- `cmd_op`, input, OPW: opcode.
- `alu_a`, `alu_b`, output, WIDTH: registered operands to the ALU `A`/`B`.
- `alu_op`, output, OPW: registered opcode to the ALU `op`.
- `alu_r`, input, WIDTH: ALU result `R`.
- `rsp_valid`, output, 1: result available at the FIFO head.
- `rsp_ready`, input, 1: consumer takes the result.
- `rsp_r`, output, WIDTH: result.
- `rsp_op`, output, OPW: opcode echoed for this result.
- `pending`, output, clog2(DEPTH)+1: in-flight operations plus FIFO occupancy.

## Operation
- Accept condition: `cmd_valid && cmd_ready` at a rising edge. On accept, `alu_a/alu_b/alu_op` load `cmd_a/cmd_b/cmd_op`. With no accept, they hold their last values.
- In-flight tracker: a shift register `ALU_LAT+1` stages deep carrying {valid, op}. Stage 0 loads on accept.
- Capture: when the final stage is valid, `alu_r` and that stage's op are written into the FIFO at `wr_ptr`.
- Pop: `rsp_valid && rsp_ready` advances `rd_ptr`.
- `rsp_r/rsp_op` show the FIFO head, read combinationally. Both are 0 after reset until the first write.
- Credit rule: `cmd_ready = (pending < DEPTH)`. `pending` counts accepted commands not yet popped. This guarantees FIFO capture never overflows.
- `cmd_ready` does not depend combinationally on `rsp_ready`. A pop frees a credit from the next cycle only.
- Simultaneous accept and pop: `pending` is unchanged. Simultaneous capture and pop: occupancy is unchanged, and both pointers advance.
- Pointers are `clog2(DEPTH)+1` bits and wrap modulo `2*DEPTH`. Full/empty are derived from the MSB compare.
- The result order always equals the command-accept order.
- Reset, asynchronous, any time, including mid-operation:
  - All in-flight stages are cleared, FIFO pointers return to 0, and memory is cleared to 0.
  - `alu_a/alu_b/alu_op` return to 0; `rsp_valid`, `rsp_r`, `rsp_op` and `pending` return to 0.
  - `cmd_ready` is 0 while `rst_n` is low and 1 from the first cycle after release.
  - Results in flight at reset are discarded and never appear on `rsp_*`.

## Timing
- Throughput: one command per clock while credits remain.
- A command accepted at edge N drives `alu_*` from edge N.
- Its result is written to the FIFO at edge N+ALU_LAT+1.
- If the FIFO was empty, `rsp_valid` rises after edge N+ALU_LAT+1. Minimum command-to-response latency is ALU_LAT+1 cycles; with ALU_LAT=1 it is 2 cycles.
- `pending` increments after the accept edge and decrements after the pop edge.
- With `rsp_ready` held low, exactly DEPTH commands are accepted. `cmd_ready` is then low until one cycle after the first pop.

## Test plan
All scenarios use a bench ALU model with `R = A ^ B ^ op`, registered through ALU_LAT stages, and default parameters.

1. Single op: after reset, `rsp_ready`=1 and command A=0x6A, B=0x3B, op=0 accepted at edge N → `alu_a`=0x6A from N; `rsp_valid` and `rsp_r`=0x51, `rsp_op`=0 after edge N+2, for one cycle.
2. Back-to-back sweep: ops 0..7 on consecutive cycles with `rsp_ready`=1 and the same A/B → `cmd_ready` never drops. Responses arrive on consecutive cycles in order: 0x51, 0x50, 0x53, 0x52, 0x55, 0x54, 0x57, 0x56.
3. Backpressure: `rsp_ready`=0 while presenting ops 0..7 → only ops 0..3 are accepted and `pending`=4. `cmd_ready` stays 0 until `rsp_ready` is pulsed for one pop, then rises the next cycle. All 8 results are eventually returned in order.
4. Simultaneous push/pop: steady stream with `rsp_ready` toggling every cycle → no lost or duplicated result, and `pending` never exceeds 4.
5. Reset mid-flight: assert `rst_n` low one cycle after accepting op 5 → all outputs read 0 and `cmd_ready`=0 during reset. After release, no response for op 5 ever appears, and a new op 2 returns 0x53.
6. Parameter sweep: ALU_LAT=0 and ALU_LAT=3 → first response appears after edge N+1 and N+4 respectively, with data identical to scenario 2.
